// File: rtl/aq_axi_local_pkg.sv
// Shared definitions for AQ local-bus bridges and masters: FSM state
// encoding, AXI response codes, arbitration flag values and a saturating
// increment helper for the failure counter.
package aq_axi_local_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WCOLLECT = 3'd1,
        ST_LOCAL    = 3'd2,
        ST_WRESP    = 3'd3,
        ST_RRESP    = 3'd4
    } bridge_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Value of the last-grant flag; it resets to GRANT_READ so the first
    // read/write conflict favours the write.
    localparam logic GRANT_READ  = 1'b0;
    localparam logic GRANT_WRITE = 1'b1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/aq_axi_local_timeout.sv
// Local-bus ACK timeout counter. While enabled, the count equals the
// ordinal of the current access cycle (1 on the first cycle), and expired
// is raised on the TIMEOUT-th cycle. TIMEOUT=0 disables expiry entirely.
module aq_axi_local_timeout #(
    parameter int TIMEOUT = 256
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] count_reg;

    // Clear preloads 1 so the first enabled cycle already counts as cycle 1.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            count_reg <= CW'(1);
        end else if (clear) begin
            count_reg <= CW'(1);
        end else if (enable) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            assign expired = enable && (count_reg == CW'(TIMEOUT));
        end
    endgenerate

endmodule

// File: rtl/aq_axi_lite_local_bridge.sv
// AXI4-Lite slave to AQ local-bus bridge. One transaction in flight;
// AW and W may arrive in either order; reads and writes alternate when
// both are pending; all responses are registered so ACK may be a pulse.
module aq_axi_lite_local_bridge
    import aq_axi_local_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic                      S_AXI_BVALID,
    output logic [1:0]                S_AXI_BRESP,
    input  logic                      S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,
    output logic                      AQ_LOCAL_CS,
    output logic                      AQ_LOCAL_RNW,
    output logic [31:0]               AQ_LOCAL_ADDR,
    output logic [DATA_WIDTH/8-1:0]   AQ_LOCAL_BE,
    output logic [DATA_WIDTH-1:0]     AQ_LOCAL_WDATA,
    input  logic [DATA_WIDTH-1:0]     AQ_LOCAL_RDATA,
    input  logic                      AQ_LOCAL_ACK,
    output logic [15:0]               TIMEOUT_COUNT
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    bridge_state_t           state_reg;
    logic                    last_grant_reg;
    logic                    aw_full_reg;
    logic                    w_full_reg;
    logic                    rnw_reg;
    logic                    cs_reg;
    logic                    bvalid_reg;
    logic                    rvalid_reg;
    logic [1:0]              resp_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [BE_WIDTH-1:0]     strb_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic [15:0]             timeout_count_reg;

    logic grant_write;
    logic grant_read;
    logic awready;
    logic wready;
    logic arready;
    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic timeout_expired;

    // Arbitration and channel READY decode; readies are combinational so a
    // request presented in IDLE is accepted in the same cycle.
    always_comb begin
        grant_write = 1'b0;
        grant_read  = 1'b0;
        awready     = 1'b0;
        wready      = 1'b0;
        arready     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                grant_write = (S_AXI_AWVALID || S_AXI_WVALID) &&
                              (!S_AXI_ARVALID || last_grant_reg == GRANT_READ);
                grant_read  = S_AXI_ARVALID && !grant_write;
                awready     = grant_write && !aw_full_reg;
                wready      = grant_write && !w_full_reg;
                arready     = grant_read;
            end
            ST_WCOLLECT: begin
                awready = !aw_full_reg;
                wready  = !w_full_reg;
            end
            default: ;
        endcase
    end

    assign aw_hs = S_AXI_AWVALID && awready;
    assign w_hs  = S_AXI_WVALID && wready;
    assign ar_hs = S_AXI_ARVALID && arready;

    aq_axi_local_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .clear   (state_reg != ST_LOCAL),
        .enable  (state_reg == ST_LOCAL),
        .expired (timeout_expired)
    );

    // Bridge FSM with registered local-bus strobes and AXI responses.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg         <= ST_IDLE;
            last_grant_reg    <= GRANT_READ;
            aw_full_reg       <= 1'b0;
            w_full_reg        <= 1'b0;
            rnw_reg           <= 1'b0;
            cs_reg            <= 1'b0;
            bvalid_reg        <= 1'b0;
            rvalid_reg        <= 1'b0;
            resp_reg          <= RESP_OKAY;
            addr_reg          <= '0;
            wdata_reg         <= '0;
            strb_reg          <= '0;
            rdata_reg         <= '0;
            timeout_count_reg <= 16'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_write) begin
                        last_grant_reg <= GRANT_WRITE;
                        rnw_reg        <= 1'b0;
                        if (aw_hs) begin
                            aw_full_reg <= 1'b1;
                            addr_reg    <= S_AXI_AWADDR;
                        end
                        if (w_hs) begin
                            w_full_reg <= 1'b1;
                            wdata_reg  <= S_AXI_WDATA;
                            strb_reg   <= S_AXI_WSTRB;
                        end
                        if (aw_hs && w_hs) begin
                            cs_reg    <= 1'b1;
                            state_reg <= ST_LOCAL;
                        end else begin
                            state_reg <= ST_WCOLLECT;
                        end
                    end else if (ar_hs) begin
                        last_grant_reg <= GRANT_READ;
                        rnw_reg        <= 1'b1;
                        addr_reg       <= S_AXI_ARADDR;
                        cs_reg         <= 1'b1;
                        state_reg      <= ST_LOCAL;
                    end
                end
                ST_WCOLLECT: begin
                    if (aw_hs) begin
                        aw_full_reg <= 1'b1;
                        addr_reg    <= S_AXI_AWADDR;
                    end
                    if (w_hs) begin
                        w_full_reg <= 1'b1;
                        wdata_reg  <= S_AXI_WDATA;
                        strb_reg   <= S_AXI_WSTRB;
                    end
                    if ((aw_full_reg || aw_hs) && (w_full_reg || w_hs)) begin
                        cs_reg    <= 1'b1;
                        state_reg <= ST_LOCAL;
                    end
                end
                ST_LOCAL: begin
                    // ACK takes priority over an expiry in the same cycle.
                    if (AQ_LOCAL_ACK) begin
                        cs_reg   <= 1'b0;
                        resp_reg <= RESP_OKAY;
                        if (rnw_reg) begin
                            rdata_reg  <= AQ_LOCAL_RDATA;
                            rvalid_reg <= 1'b1;
                            state_reg  <= ST_RRESP;
                        end else begin
                            bvalid_reg <= 1'b1;
                            state_reg  <= ST_WRESP;
                        end
                    end else if (timeout_expired) begin
                        cs_reg            <= 1'b0;
                        resp_reg          <= RESP_SLVERR;
                        timeout_count_reg <= sat_inc16(timeout_count_reg);
                        if (rnw_reg) begin
                            rdata_reg  <= '0;
                            rvalid_reg <= 1'b1;
                            state_reg  <= ST_RRESP;
                        end else begin
                            bvalid_reg <= 1'b1;
                            state_reg  <= ST_WRESP;
                        end
                    end
                end
                ST_WRESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_reg  <= 1'b0;
                        aw_full_reg <= 1'b0;
                        w_full_reg  <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end
                end
                ST_RRESP: begin
                    if (S_AXI_RREADY) begin
                        rvalid_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY  = awready;
    assign S_AXI_WREADY   = wready;
    assign S_AXI_ARREADY  = arready;
    assign S_AXI_BVALID   = bvalid_reg;
    assign S_AXI_BRESP    = resp_reg;
    assign S_AXI_RVALID   = rvalid_reg;
    assign S_AXI_RRESP    = resp_reg;
    assign S_AXI_RDATA    = rdata_reg;
    assign AQ_LOCAL_CS    = cs_reg;
    assign AQ_LOCAL_RNW   = rnw_reg;
    assign AQ_LOCAL_ADDR  = 32'(addr_reg);
    assign AQ_LOCAL_BE    = rnw_reg ? '0 : strb_reg;
    assign AQ_LOCAL_WDATA = wdata_reg;
    assign TIMEOUT_COUNT  = timeout_count_reg;

endmodule

// File: tb/tb_aq_axi_lite_local_bridge.sv
// Directed bench for the AXI4-Lite to AQ local-bus bridge: a 32-bit
// instance with TIMEOUT=8 and a 64-bit instance for wide strobes.
module tb_aq_axi_lite_local_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aresetn;
    logic [15:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata, lwdata, lrdata, laddr;
    logic [3:0]  wstrb, be;
    logic [1:0]  bresp, rresp;
    logic        cs, rnw, ack;
    logic [15:0] tcount;

    logic [15:0] x_awaddr, x_araddr;
    logic        x_awvalid, x_awready, x_wvalid, x_wready, x_bvalid, x_bready;
    logic        x_arvalid, x_arready, x_rvalid, x_rready;
    logic [63:0] x_wdata, x_rdata, x_lwdata, x_lrdata;
    logic [31:0] x_laddr;
    logic [7:0]  x_wstrb, x_be;
    logic [1:0]  x_bresp, x_rresp;
    logic        x_cs, x_rnw, x_ack;
    logic [15:0] x_tcount;

    int n_checks = 0;
    int n_fail   = 0;

    aq_axi_lite_local_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
        .ACLK(clk), .ARESETN(aresetn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BVALID(bvalid), .S_AXI_BRESP(bresp), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .AQ_LOCAL_CS(cs), .AQ_LOCAL_RNW(rnw), .AQ_LOCAL_ADDR(laddr), .AQ_LOCAL_BE(be),
        .AQ_LOCAL_WDATA(lwdata), .AQ_LOCAL_RDATA(lrdata), .AQ_LOCAL_ACK(ack),
        .TIMEOUT_COUNT(tcount)
    );

    aq_axi_lite_local_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .TIMEOUT(8)) dut64 (
        .ACLK(clk), .ARESETN(aresetn),
        .S_AXI_AWADDR(x_awaddr), .S_AXI_AWVALID(x_awvalid), .S_AXI_AWREADY(x_awready),
        .S_AXI_WDATA(x_wdata), .S_AXI_WSTRB(x_wstrb), .S_AXI_WVALID(x_wvalid), .S_AXI_WREADY(x_wready),
        .S_AXI_BVALID(x_bvalid), .S_AXI_BRESP(x_bresp), .S_AXI_BREADY(x_bready),
        .S_AXI_ARADDR(x_araddr), .S_AXI_ARVALID(x_arvalid), .S_AXI_ARREADY(x_arready),
        .S_AXI_RDATA(x_rdata), .S_AXI_RRESP(x_rresp), .S_AXI_RVALID(x_rvalid), .S_AXI_RREADY(x_rready),
        .AQ_LOCAL_CS(x_cs), .AQ_LOCAL_RNW(x_rnw), .AQ_LOCAL_ADDR(x_laddr), .AQ_LOCAL_BE(x_be),
        .AQ_LOCAL_WDATA(x_lwdata), .AQ_LOCAL_RDATA(x_lrdata), .AQ_LOCAL_ACK(x_ack),
        .TIMEOUT_COUNT(x_tcount)
    );

    // Move to just after the next rising edge (input drive point).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge (output sample point).
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        aresetn = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0; lrdata = '0; ack = 0;
        x_awaddr = '0; x_awvalid = 0; x_wdata = '0; x_wstrb = '0; x_wvalid = 0; x_bready = 0;
        x_araddr = '0; x_arvalid = 0; x_rready = 0; x_lrdata = '0; x_ack = 0;
        #2 aresetn = 1'b0;
        repeat (2) cyc();
        smp();
        n_checks++; if ({awready, wready, arready} !== 3'b000) begin n_fail++; $display("FAIL rst_ready: got %b want 000", {awready, wready, arready}); end
        n_checks++; if ({bvalid, rvalid, cs, rnw} !== 4'b0000) begin n_fail++; $display("FAIL rst_valid_cs_rnw: got %b want 0000", {bvalid, rvalid, cs, rnw}); end
        n_checks++; if ({bresp, rresp} !== 4'b0000) begin n_fail++; $display("FAIL rst_resp: got %b want 0000", {bresp, rresp}); end
        n_checks++; if (rdata !== 32'h0 || laddr !== 32'h0 || lwdata !== 32'h0 || be !== 4'h0) begin n_fail++; $display("FAIL rst_data: rdata=%h addr=%h wdata=%h be=%h want all 0", rdata, laddr, lwdata, be); end
        n_checks++; if (tcount !== 16'd0) begin n_fail++; $display("FAIL rst_tcount: got %0d want 0", tcount); end
        n_checks++; if (x_cs !== 1'b0 || x_be !== 8'h0) begin n_fail++; $display("FAIL rst_wide: cs=%b be=%h want 0/00", x_cs, x_be); end
        cyc();
        aresetn = 1'b1;
        $display("reset released");
    endtask

    task automatic test_arbitration();
        cyc();
        awvalid = 1; awaddr = 16'h0030; wvalid = 1; wdata = 32'h3030_3030; wstrb = 4'hF;
        arvalid = 1; araddr = 16'h0034;
        smp();
        n_checks++; if ({awready, wready, arready} !== 3'b110) begin n_fail++; $display("FAIL arb1_grant_write: got aw/w/ar=%b want 110", {awready, wready, arready}); end
        cyc(); awvalid = 0; wvalid = 0; ack = 1;
        smp();
        n_checks++; if (cs !== 1'b1 || rnw !== 1'b0 || laddr !== 32'h30) begin n_fail++; $display("FAIL arb1_local: cs=%b rnw=%b addr=%h want 1/0/30", cs, rnw, laddr); end
        n_checks++; if (arready !== 1'b0) begin n_fail++; $display("FAIL arb1_arready_local: got %b want 0", arready); end
        cyc(); ack = 0; bready = 1;
        smp();
        n_checks++; if (bvalid !== 1'b1 || arready !== 1'b0) begin n_fail++; $display("FAIL arb1_wresp: bvalid=%b arready=%b want 1/0", bvalid, arready); end
        cyc(); bready = 0;
        $display("arb write addr=0030 granted first");
        awvalid = 1; awaddr = 16'h0038; wvalid = 1; wdata = 32'h3838_3838;
        smp();
        n_checks++; if ({awready, wready, arready} !== 3'b001) begin n_fail++; $display("FAIL arb2_grant_read: got aw/w/ar=%b want 001", {awready, wready, arready}); end
        cyc(); arvalid = 0; lrdata = 32'h0BAD_F00D; ack = 1;
        smp();
        n_checks++; if (cs !== 1'b1 || rnw !== 1'b1 || laddr !== 32'h34 || be !== 4'h0) begin n_fail++; $display("FAIL arb2_local: cs=%b rnw=%b addr=%h be=%h want 1/1/34/0", cs, rnw, laddr, be); end
        n_checks++; if ({awready, wready} !== 2'b00) begin n_fail++; $display("FAIL arb2_wr_blocked: got %b want 00", {awready, wready}); end
        cyc(); ack = 0; rready = 1;
        smp();
        n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h0BAD_F00D || rresp !== 2'b00) begin n_fail++; $display("FAIL arb2_rresp: rvalid=%b rdata=%h rresp=%b want 1/0badf00d/00", rvalid, rdata, rresp); end
        cyc(); rready = 0;
        $display("arb read addr=0034 granted second rdata=%h", rdata);
        smp();
        n_checks++; if ({awready, wready} !== 2'b11) begin n_fail++; $display("FAIL arb3_write_after_read: got %b want 11", {awready, wready}); end
        cyc(); awvalid = 0; wvalid = 0; ack = 1;
        smp();
        n_checks++; if (cs !== 1'b1 || laddr !== 32'h38 || lwdata !== 32'h3838_3838) begin n_fail++; $display("FAIL arb3_local: cs=%b addr=%h wdata=%h want 1/38/38383838", cs, laddr, lwdata); end
        cyc(); ack = 0; bready = 1;
        smp();
        n_checks++; if (bvalid !== 1'b1) begin n_fail++; $display("FAIL arb3_bvalid: got %b want 1", bvalid); end
        cyc(); bready = 0;
        $display("arb write addr=0038 completed");
    endtask

    task automatic test_write_basic();
        cyc();
        awvalid = 1; awaddr = 16'h0010; wvalid = 1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        smp();
        n_checks++; if ({awready, wready} !== 2'b11) begin n_fail++; $display("FAIL wr_ready: got %b want 11", {awready, wready}); end
        cyc(); awvalid = 0; wvalid = 0;
        smp();
        n_checks++; if (cs !== 1'b1 || laddr !== 32'h10 || lwdata !== 32'hDEAD_BEEF || be !== 4'hF) begin n_fail++; $display("FAIL wr_local: cs=%b addr=%h wdata=%h be=%h want 1/10/deadbeef/f", cs, laddr, lwdata, be); end
        cyc();
        smp();
        n_checks++; if (cs !== 1'b1 || bvalid !== 1'b0) begin n_fail++; $display("FAIL wr_wait: cs=%b bvalid=%b want 1/0", cs, bvalid); end
        cyc(); ack = 1;
        smp();
        n_checks++; if (cs !== 1'b1) begin n_fail++; $display("FAIL wr_cs_ack_cycle: got %b want 1", cs); end
        cyc(); ack = 0; bready = 1;
        smp();
        n_checks++; if (cs !== 1'b0 || bvalid !== 1'b1 || bresp !== 2'b00) begin n_fail++; $display("FAIL wr_bresp: cs=%b bvalid=%b bresp=%b want 0/1/00", cs, bvalid, bresp); end
        cyc(); bready = 0;
        smp();
        n_checks++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL wr_bvalid_clear: got %b want 0", bvalid); end
        cyc(); ack = 1;
        smp();
        cyc(); ack = 0;
        smp();
        n_checks++; if ({cs, bvalid, rvalid} !== 3'b000) begin n_fail++; $display("FAIL stray_ack: cs/b/r=%b want 000", {cs, bvalid, rvalid}); end
        $display("write addr=0010 data=deadbeef bresp=00");
    endtask

    task automatic test_w_before_aw();
        cyc();
        wvalid = 1; wdata = 32'hA5A5_A5A5; wstrb = 4'h3;
        smp();
        n_checks++; if ({awready, wready} !== 2'b11) begin n_fail++; $display("FAIL wfirst_c0: aw/w=%b want 11", {awready, wready}); end
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k == 1) wvalid = 0;
            if (k == 4) begin awvalid = 1; awaddr = 16'h0044; end
            smp();
            n_checks++; if (wready !== 1'b0 || cs !== 1'b0) begin n_fail++; $display("FAIL wfirst_collect_c%0d: wready=%b cs=%b want 0/0", k, wready, cs); end
            if (k == 4) begin
                n_checks++; if (awready !== 1'b1) begin n_fail++; $display("FAIL wfirst_awready: got %b want 1", awready); end
            end
        end
        cyc(); awvalid = 0; ack = 1;
        smp();
        n_checks++; if (cs !== 1'b1 || laddr !== 32'h44 || be !== 4'h3 || lwdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL wfirst_local_c5: cs=%b addr=%h be=%h wdata=%h want 1/44/3/a5a5a5a5", cs, laddr, be, lwdata); end
        cyc(); ack = 0;
        smp();
        n_checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin n_fail++; $display("FAIL wfirst_bresp: bvalid=%b bresp=%b want 1/00", bvalid, bresp); end
        cyc();
        smp();
        n_checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin n_fail++; $display("FAIL wfirst_b_stable: bvalid=%b bresp=%b want 1/00", bvalid, bresp); end
        cyc(); bready = 1;
        smp();
        cyc(); bready = 0;
        smp();
        n_checks++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL wfirst_b_done: got %b want 0", bvalid); end
        $display("write (W before AW) addr=0044 data=a5a5a5a5 bresp=00");
    endtask

    task automatic test_read_backpressure();
        cyc();
        arvalid = 1; araddr = 16'h0020;
        smp();
        n_checks++; if (arready !== 1'b1) begin n_fail++; $display("FAIL rd_arready: got %b want 1", arready); end
        cyc(); arvalid = 0; lrdata = 32'h1234_5678; ack = 1;
        smp();
        n_checks++; if (cs !== 1'b1 || rnw !== 1'b1 || laddr !== 32'h20 || be !== 4'h0) begin n_fail++; $display("FAIL rd_local: cs=%b rnw=%b addr=%h be=%h want 1/1/20/0", cs, rnw, laddr, be); end
        cyc(); ack = 0; lrdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            smp();
            n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h1234_5678 || rresp !== 2'b00) begin n_fail++; $display("FAIL rd_hold_%0d: rvalid=%b rdata=%h rresp=%b want 1/12345678/00", k, rvalid, rdata, rresp); end
            cyc();
        end
        rready = 1;
        smp();
        n_checks++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_hs_cycle: got %b want 1", rvalid); end
        cyc(); rready = 0;
        smp();
        n_checks++; if (rvalid !== 1'b0 || cs !== 1'b0) begin n_fail++; $display("FAIL rd_idle: rvalid=%b cs=%b want 0/0", rvalid, cs); end
        $display("read addr=0020 rdata=12345678 rresp=00");
    endtask

    task automatic test_timeout();
        int cs_cycles;
        cyc();
        arvalid = 1; araddr = 16'h0050;
        smp();
        cyc(); arvalid = 0;
        cs_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            smp();
            if (cs !== 1'b1) break;
            cs_cycles++;
            cyc();
        end
        n_checks++; if (cs_cycles != 8) begin n_fail++; $display("FAIL to_cs_cycles: got %0d want 8", cs_cycles); end
        n_checks++; if (rvalid !== 1'b1 || rresp !== 2'b10 || rdata !== 32'h0) begin n_fail++; $display("FAIL to_rresp: rvalid=%b rresp=%b rdata=%h want 1/10/0", rvalid, rresp, rdata); end
        n_checks++; if (tcount !== 16'd1) begin n_fail++; $display("FAIL to_count: got %0d want 1", tcount); end
        cyc(); rready = 1;
        smp();
        cyc(); rready = 0;
        $display("read addr=0050 timed out rresp=10 count=%0d", tcount);
    endtask

    task automatic test_ack_at_expiry();
        cyc();
        arvalid = 1; araddr = 16'h0054;
        smp();
        cyc(); arvalid = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) begin ack = 1; lrdata = 32'hCAFE_F00D; end
            smp();
            if (i == 8) begin
                n_checks++; if (cs !== 1'b1) begin n_fail++; $display("FAIL ackexp_cs_c8: got %b want 1", cs); end
            end
            cyc();
        end
        ack = 0;
        smp();
        n_checks++; if (rvalid !== 1'b1 || rresp !== 2'b00 || rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL ackexp_rresp: rvalid=%b rresp=%b rdata=%h want 1/00/cafef00d", rvalid, rresp, rdata); end
        n_checks++; if (tcount !== 16'd1 || cs !== 1'b0) begin n_fail++; $display("FAIL ackexp_count: count=%0d cs=%b want 1/0", tcount, cs); end
        cyc(); rready = 1;
        smp();
        cyc(); rready = 0;
        $display("read addr=0054 ack at expiry rdata=cafef00d rresp=00");
    endtask

    task automatic test_reset_mid();
        cyc();
        awvalid = 1; awaddr = 16'h0058; wvalid = 1; wdata = 32'h5858_5858; wstrb = 4'hF;
        smp();
        cyc(); awvalid = 0; wvalid = 0;
        smp();
        n_checks++; if (cs !== 1'b1) begin n_fail++; $display("FAIL rstmid_cs_before: got %b want 1", cs); end
        cyc();
        aresetn = 1'b0;
        #1;
        n_checks++; if (cs !== 1'b0 || tcount !== 16'd0) begin n_fail++; $display("FAIL rstmid_async: cs=%b count=%0d want 0/0", cs, tcount); end
        cyc();
        cyc(); aresetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            smp();
            n_checks++; if ({bvalid, rvalid, cs} !== 3'b000) begin n_fail++; $display("FAIL rstmid_no_resp_%0d: b/r/cs=%b want 000", k, {bvalid, rvalid, cs}); end
            cyc();
        end
        awvalid = 1; awaddr = 16'h0060; wvalid = 1; wdata = 32'h1122_3344; wstrb = 4'hC;
        smp();
        cyc(); awvalid = 0; wvalid = 0; ack = 1;
        smp();
        n_checks++; if (cs !== 1'b1 || laddr !== 32'h60 || lwdata !== 32'h1122_3344 || be !== 4'hC) begin n_fail++; $display("FAIL rstmid_next_local: cs=%b addr=%h wdata=%h be=%h want 1/60/11223344/c", cs, laddr, lwdata, be); end
        cyc(); ack = 0; bready = 1;
        smp();
        n_checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin n_fail++; $display("FAIL rstmid_next_b: bvalid=%b bresp=%b want 1/00", bvalid, bresp); end
        cyc(); bready = 0;
        $display("write after mid-reset addr=0060 data=11223344 bresp=00");
    endtask

    task automatic test_wide();
        cyc();
        x_awvalid = 1; x_awaddr = 16'h0008; x_wvalid = 1; x_wdata = 64'h0123_4567_89AB_CDEF; x_wstrb = 8'h0F;
        smp();
        n_checks++; if ({x_awready, x_wready} !== 2'b11) begin n_fail++; $display("FAIL wide_ready: got %b want 11", {x_awready, x_wready}); end
        cyc(); x_awvalid = 0; x_wvalid = 0; x_ack = 1;
        smp();
        n_checks++; if (x_cs !== 1'b1 || x_be !== 8'h0F || x_lwdata !== 64'h0123_4567_89AB_CDEF || x_laddr !== 32'h8) begin n_fail++; $display("FAIL wide_local: cs=%b be=%h wdata=%h addr=%h want 1/0f/0123456789abcdef/8", x_cs, x_be, x_lwdata, x_laddr); end
        cyc(); x_ack = 0; x_bready = 1;
        smp();
        n_checks++; if (x_bvalid !== 1'b1 || x_bresp !== 2'b00) begin n_fail++; $display("FAIL wide_b: bvalid=%b bresp=%b want 1/00", x_bvalid, x_bresp); end
        cyc(); x_bready = 0;
        $display("wide write addr=0008 data=0123456789abcdef be=0f");
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_write_basic();
        test_w_before_aw();
        test_read_backpressure();
        test_timeout();
        test_ack_at_expiry();
        test_reset_mid();
        test_wide();
        repeat (2) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aq_axi_lite_local_bridge.md
# aq_axi_lite_local_bridge

Parametrised AXI4-Lite slave to AQ local-bus bridge, the successor of the fixed 16/32-bit bridge used by the AQUAXIS peripherals. It accepts AW and W in either order, arbitrates fairly between reads and writes, and registers all responses, so the local ACK may be a single-cycle pulse. A programmable ACK timeout returns SLVERR and counts failures. It sits between the AXI interconnect and one peripheral register file.

## Interface
- ADDR_WIDTH, 16, AXI address width; zero-extended onto AQ_LOCAL_ADDR.
- DATA_WIDTH, 32, data width; 32 or 64. BE width = DATA_WIDTH/8.
- TIMEOUT, 256, cycles CS may stay high without ACK; 0 disables timeout.
- ACLK  in  1  clock.
- ARESETN  in  1  reset, asynchronous, active-low.
- S_AXI_AW{ADDR[ADDR_WIDTH],VALID} in, S_AXI_AWREADY out: write address.
- S_AXI_W{DATA[DATA_WIDTH],STRB[DATA_WIDTH/8],VALID} in, S_AXI_WREADY out: write data.
- S_AXI_BVALID out 1, S_AXI_BRESP out 2, S_AXI_BREADY in 1: write response.
- S_AXI_ARADDR in ADDR_WIDTH, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address.
- S_AXI_RDATA out DATA_WIDTH, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data.
- AQ_LOCAL_CS/RNW out 1; AQ_LOCAL_ADDR out 32; AQ_LOCAL_BE out DATA_WIDTH/8; AQ_LOCAL_WDATA out DATA_WIDTH; AQ_LOCAL_RDATA in DATA_WIDTH; AQ_LOCAL_ACK in 1: local bus.
- TIMEOUT_COUNT  out  16  saturating count of timed-out accesses.
- AXI CACHE/PROT inputs are not present.

## Operation
- States: IDLE, WCOLLECT, LOCAL, WRESP, RRESP.
- IDLE arbitration:
  - Write request = AWVALID|WVALID. Read request = ARVALID.
  - If both are pending, grant goes to the type not granted last. A 1-bit last_grant flag is updated on every grant and resets to "read", so the first conflict grants the write.
- Write grant:
  - AWREADY=1 while the AW slot is empty; WREADY=1 while the W slot is empty. Each slot captures on its own handshake.
  - Both slots full → LOCAL; otherwise → WCOLLECT, which waits for the missing channel.
  - ARREADY=0 from the write grant until the write response completes.
- Read grant: ARREADY=1, ARADDR captured, → LOCAL with RNW=1. AWREADY and WREADY are 0 from the grant until the read response completes.
- LOCAL:
  - CS=1; ADDR/BE/WDATA/RNW driven from the capture registers. BE=0 for reads.
  - ACK → capture RDATA (reads only), RESP=OKAY, → WRESP or RRESP.
  - Timeout counter reaches TIMEOUT with no ACK → RESP=SLVERR (2'b10), RDATA=0, TIMEOUT_COUNT+1 (saturating at 16'hFFFF), → WRESP or RRESP.
- WRESP: BVALID=1 until BREADY, then clear both write slots and → IDLE.
- RRESP: RVALID=1 with registered RDATA/RRESP until RREADY, then → IDLE.
- ACK outside LOCAL is ignored. One outstanding transaction only.

## Timing
- Reset values: all READY/VALID/CS = 0; RESP = 0; RDATA/ADDR/WDATA/BE = 0; RNW = 0; TIMEOUT_COUNT = 0; state = IDLE; slots empty.
- Write, AW+W together in cycle 0: CS=1 from cycle 1. ACK in cycle n → CS=0 and BVALID=1 in cycle n+1.
- Read, AR in cycle 0: CS=1 from cycle 1. ACK in cycle n → RVALID=1 in cycle n+1 with the data sampled at n.
- Zero-wait local target (ACK in cycle 1) gives BVALID/RVALID in cycle 2.
- Response handshake in cycle m → IDLE in cycle m+1; the next grant can occur in cycle m+1.
- Timeout: CS high for exactly TIMEOUT cycles (counter starts at 1 on the first LOCAL cycle). Response VALID follows in the next cycle.
- An ACK in the same cycle the counter expires wins: response is OKAY.
- VALID and RESP/RDATA remain stable while VALID && !READY.
- ARESETN asserted mid-transaction: immediate return to IDLE, CS drops asynchronously, no response is issued, TIMEOUT_COUNT clears.

## Structure
- Package aq_axi_local_pkg: state encoding localparams and RESP_OKAY/RESP_SLVERR constants, shared with future local-bus masters.
- Sub-module aq_axi_local_timeout: clear/enable counter with TIMEOUT compare and an expired output. Permanently 0 when TIMEOUT=0.

## Test plan
- AW+W in the same cycle, addr 16'h0010, data 32'hDEADBEEF, strb 4'hF, ACK in the 3rd LOCAL cycle → ADDR=32'h10, WDATA=DEADBEEF, BE=F while CS; BVALID one cycle after ACK with BRESP=00.
- W in cycle 0, AW in cycle 4 → WCOLLECT holds; CS first high in cycle 5; WREADY=0 during cycles 1-4.
- AR and AW+W asserted together twice in succession → write granted first, read second; ARREADY=0 while the write is in flight.
- Read, addr 16'h0020, ACK with RDATA=32'h12345678, RREADY held low 5 cycles → RVALID and RDATA stable until RREADY; IDLE the next cycle.
- TIMEOUT=8, target never ACKs → CS high exactly 8 cycles, RRESP=10, RDATA=0, TIMEOUT_COUNT=1. Same access with ACK in the 8th cycle → OKAY, count unchanged.
- ARESETN low during LOCAL → CS=0 immediately, no B/R response, next write completes normally; DATA_WIDTH=64 run with strb 8'h0F → BE=8'h0F.
